// File: rtl/jtbubl_gfx_romfetch.sv
// 32-bit graphics ROM port served by two 16-bit SDRAM reads, with a one-word tag/data cache.
// Define JTBUBL_ROMFETCH_CACHE_EN to keep the cached word valid while gfx_cs is low.
`timescale 1ns/1ps
module jtbubl_gfx_romfetch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gfx_cs,
    input  logic [17:0] gfx_addr,
    output logic [31:0] gfx_data,
    output logic        gfx_ok,
    output logic        sdram_req,
    output logic [18:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        sdram_rdy,
    input  logic [15:0] sdram_din
);

`ifdef JTBUBL_ROMFETCH_CACHE_EN
    localparam bit KEEP_VALID = 1'b1;
`else
    localparam bit KEEP_VALID = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_LO  = 3'd1,
        WAIT_LO = 3'd2,
        REQ_HI  = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [17:0] tag_q, tag_d;
    logic [17:0] fetch_addr_q, fetch_addr_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        hit;

    assign hit        = valid_q & gfx_cs & (gfx_addr == tag_q);
    assign gfx_ok     = hit;
    assign gfx_data   = data_q;
    assign sdram_req  = (state_q == REQ_LO) | (state_q == REQ_HI);
    // Address is derived from the latched fetch address only, so it cannot move under a pending request.
    assign sdram_addr = {fetch_addr_q, state_q == REQ_HI};

    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        fetch_addr_d = fetch_addr_q;
        data_d       = data_q;
        valid_d      = valid_q;

        case (state_q)
            IDLE: begin
                if (gfx_cs && !hit) begin
                    fetch_addr_d = gfx_addr;
                    valid_d      = 1'b0;
                    state_d      = REQ_LO;
                end
            end
            REQ_LO: begin
                if (sdram_ack) state_d = WAIT_LO;
            end
            WAIT_LO: begin
                if (sdram_rdy) begin
                    data_d[15:0] = sdram_din;
                    state_d      = REQ_HI;
                end
            end
            REQ_HI: begin
                if (sdram_ack) state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (sdram_rdy) begin
                    data_d[31:16] = sdram_din;
                    tag_d         = fetch_addr_q;
                    valid_d       = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Without the persistent cache, any idle cycle on gfx_cs forces a refetch.
        if (!KEEP_VALID && !gfx_cs) valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tag_q        <= '0;
            fetch_addr_q <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            fetch_addr_q <= fetch_addr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
        end
    end

endmodule

// File: tb/tb_jtbubl_gfx_romfetch.sv
// Self-checking bench for jtbubl_gfx_romfetch: SDRAM model with programmable ack/rdy delays.
`timescale 1ns/1ps
module tb_jtbubl_gfx_romfetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gfx_cs = 1'b0;
    logic [17:0] gfx_addr = '0;
    logic [31:0] gfx_data;
    logic        gfx_ok;
    logic        sdram_req;
    logic [18:0] sdram_addr;
    logic        sdram_ack;
    logic        sdram_rdy;
    logic [15:0] sdram_din;

    int vectors = 0;
    int miscompares = 0;

    int ack_wait = 0;
    int rdy_gap = 1;
    int wait_cnt = 0;
    int rdy_cnt = 0;
    logic [18:0] pend_addr = '0;

    logic [18:0] hs_q[$];
    int unstable = 0;
    logic prev_req = 1'b0;
    logic [18:0] prev_addr = '0;

    jtbubl_gfx_romfetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gfx_cs     (gfx_cs),
        .gfx_addr   (gfx_addr),
        .gfx_data   (gfx_data),
        .gfx_ok     (gfx_ok),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_din  (sdram_din)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [15:0] mem16(input logic [18:0] a);
        logic [15:0] h;
        if (a == 19'h00246) return 16'hBEEF;
        if (a == 19'h00247) return 16'hDEAD;
        h = a[15:0] * 16'h9E37;
        return h ^ {a[18:16], 13'h0A5A};
    endfunction

    function automatic logic [31:0] exp_word(input logic [17:0] a);
        return {mem16({a, 1'b1}), mem16({a, 1'b0})};
    endfunction

    // SDRAM model: ack after ack_wait cycles of req, rdy rdy_gap cycles after ack, garbage otherwise.
    initial begin
        sdram_ack = 1'b0;
        sdram_rdy = 1'b0;
        sdram_din = '0;
        forever begin
            @(posedge clk);
            #2;
            sdram_ack = 1'b0;
            sdram_rdy = 1'b0;
            sdram_din = 16'($urandom);
            if (rdy_cnt > 0) begin
                rdy_cnt--;
                if (rdy_cnt == 0) begin
                    sdram_rdy = 1'b1;
                    sdram_din = mem16(pend_addr);
                end
            end
            if (sdram_req && rst_n) begin
                if (wait_cnt >= ack_wait) begin
                    sdram_ack = 1'b1;
                    pend_addr = sdram_addr;
                    rdy_cnt   = rdy_gap;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && sdram_req && sdram_ack) hs_q.push_back(sdram_addr);
            if (rst_n && sdram_req && prev_req && sdram_addr != prev_addr) unstable++;
            prev_req  = sdram_req & rst_n;
            prev_addr = sdram_addr;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst_n    = 1'b0;
        gfx_cs   = 1'b0;
        gfx_addr = '0;
        tick(2);
        rst_n    = 1'b1;
        rdy_cnt  = 0;
        wait_cnt = 0;
        ack_wait = 0;
        rdy_gap  = 1;
        hs_q.delete();
        unstable = 0;
    endtask

    task automatic wait_ok(input int bound, output bit got);
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (gfx_ok) begin
                got = 1'b1;
                break;
            end
            tick(1);
        end
        if (!got && gfx_ok) got = 1'b1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        gfx_cs   = 1'b1;
        gfx_addr = 18'h00000;
        tick(3);
        vectors++; if (sdram_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", sdram_req); end
        vectors++; if (sdram_addr !== 19'h0) begin miscompares++; $display("FAIL reset_addr: got %h want 00000", sdram_addr); end
        vectors++; if (gfx_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h want 00000000", gfx_data); end
        vectors++; if (gfx_ok !== 1'b0) begin miscompares++; $display("FAIL reset_ok: got %b want 0 (addr matches reset tag)", gfx_ok); end
        $display("reset: req=%b addr=%h data=%h ok=%b", sdram_req, sdram_addr, gfx_data, gfx_ok);
        gfx_cs = 1'b0;
    endtask

    // Full miss timeline from an idle, non-matching cache: c0 is the cycle inputs are applied.
    task automatic test_miss_timing(input string name, input logic [17:0] a, input int aw, input int rg);
        int   len;
        logic exp_req;
        logic exp_half;
        logic exp_ok;
        ack_wait = aw;
        rdy_gap  = rg;
        len      = aw + 1 + rg;
        gfx_addr = a;
        gfx_cs   = 1'b1;
        for (int k = 1; k <= 2 * len + 2; k++) begin
            tick(1);
            exp_req  = (k <= aw + 1) || (k >= 1 + len && k <= 1 + len + aw);
            exp_half = (k >= 1 + len);
            exp_ok   = (k >= 1 + 2 * len);
            vectors++; if (sdram_req !== exp_req) begin miscompares++; $display("FAIL %s_req c%0d: got %b want %b", name, k, sdram_req, exp_req); end
            if (exp_req) begin
                vectors++; if (sdram_addr !== {a, exp_half}) begin miscompares++; $display("FAIL %s_addr c%0d: got %h want %h", name, k, sdram_addr, {a, exp_half}); end
            end
            vectors++; if (gfx_ok !== exp_ok) begin miscompares++; $display("FAIL %s_ok c%0d: got %b want %b", name, k, gfx_ok, exp_ok); end
        end
        vectors++; if (gfx_data !== exp_word(a)) begin miscompares++; $display("FAIL %s_data: got %h want %h", name, gfx_data, exp_word(a)); end
        vectors++; if (hs_q.size() != 2) begin miscompares++; $display("FAIL %s_hs_count: got %0d want 2", name, hs_q.size()); end
        if (hs_q.size() == 2) begin
            vectors++; if (hs_q[0] !== {a, 1'b0} || hs_q[1] !== {a, 1'b1}) begin miscompares++; $display("FAIL %s_hs_addr: got %h,%h want %h,%h", name, hs_q[0], hs_q[1], {a, 1'b0}, {a, 1'b1}); end
        end
        vectors++; if (unstable != 0) begin miscompares++; $display("FAIL %s_addr_stable: got %0d changes want 0", name, unstable); end
        $display("miss %s: addr=%h ack_wait=%0d rdy_gap=%0d data=%h", name, a, aw, rg, gfx_data);
    endtask

    task automatic test_basic_miss;
        do_reset();
        test_miss_timing("basic", 18'h00123, 0, 1);
        vectors++; if (gfx_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL basic_word: got %h want deadbeef", gfx_data); end
    endtask

    task automatic test_hold;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            vectors++; if (gfx_ok !== 1'b1) begin miscompares++; $display("FAIL hold_ok cyc%0d: got %b want 1", i, gfx_ok); end
        end
        vectors++; if (hs_q.size() != 2) begin miscompares++; $display("FAIL hold_hs_count: got %0d want 2", hs_q.size()); end
        $display("hold: addr=%h 20 cycles, handshakes=%0d", gfx_addr, hs_q.size());
    endtask

    task automatic test_addr_change;
        logic        exp_req;
        logic [18:0] exp_addr;
        do_reset();
        gfx_cs   = 1'b1;
        gfx_addr = 18'h00123;
        for (int k = 1; k <= 11; k++) begin
            tick(1);
            exp_req  = (k == 1 || k == 3 || k == 6 || k == 8);
            exp_addr = (k == 1) ? 19'h00246 : (k == 3) ? 19'h00247 : (k == 6) ? 19'h00248 : 19'h00249;
            vectors++; if (sdram_req !== exp_req) begin miscompares++; $display("FAIL chg_req c%0d: got %b want %b", k, sdram_req, exp_req); end
            if (exp_req) begin
                vectors++; if (sdram_addr !== exp_addr) begin miscompares++; $display("FAIL chg_addr c%0d: got %h want %h", k, sdram_addr, exp_addr); end
            end
            vectors++; if (gfx_ok !== (k >= 10)) begin miscompares++; $display("FAIL chg_ok c%0d: got %b want %b", k, gfx_ok, k >= 10); end
            if (k == 5) begin
                vectors++; if (gfx_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL chg_old_data: got %h want deadbeef", gfx_data); end
            end
            if (k == 2) gfx_addr = 18'h00124;
        end
        vectors++; if (gfx_data !== exp_word(18'h00124)) begin miscompares++; $display("FAIL chg_new_data: got %h want %h", gfx_data, exp_word(18'h00124)); end
        vectors++; if (hs_q.size() != 4) begin miscompares++; $display("FAIL chg_hs_count: got %0d want 4", hs_q.size()); end
        $display("addr change: 00123 -> 00124 mid-fetch, data=%h handshakes=%0d", gfx_data, hs_q.size());
    endtask

    task automatic test_slow_sdram;
        do_reset();
        test_miss_timing("slow", 18'($urandom), 3, 3);
        do_reset();
        test_miss_timing("top", 18'h3FFFF, 1, 2);
    endtask

    task automatic test_reset_mid_fetch;
        logic [17:0] a;
        bit          got;
        do_reset();
        a        = 18'($urandom);
        ack_wait = 0;
        rdy_gap  = 3;
        gfx_cs   = 1'b1;
        gfx_addr = a;
        tick(6);
        vectors++; if (gfx_data[15:0] !== mem16({a, 1'b0})) begin miscompares++; $display("FAIL rmid_lo: got %h want %h", gfx_data[15:0], mem16({a, 1'b0})); end
        rst_n  = 1'b0;
        gfx_cs = 1'b0;
        tick(1);
        rst_n = 1'b1;
        vectors++; if (sdram_req !== 1'b0) begin miscompares++; $display("FAIL rmid_req: got %b want 0", sdram_req); end
        vectors++; if (sdram_addr !== 19'h0) begin miscompares++; $display("FAIL rmid_addr: got %h want 00000", sdram_addr); end
        vectors++; if (gfx_data !== 32'h0) begin miscompares++; $display("FAIL rmid_data: got %h want 00000000", gfx_data); end
        tick(2);
        vectors++; if (gfx_data !== 32'h0) begin miscompares++; $display("FAIL rmid_stale_data: got %h want 00000000", gfx_data); end
        gfx_cs = 1'b1;
        #1;
        vectors++; if (gfx_ok !== 1'b0) begin miscompares++; $display("FAIL rmid_stale_valid: got %b want 0", gfx_ok); end
        wait_ok(30, got);
        vectors++; if (!got) begin miscompares++; $display("FAIL rmid_refetch: got no ok want ok within 30 cycles"); end
        vectors++; if (gfx_data !== exp_word(a)) begin miscompares++; $display("FAIL rmid_refetch_data: got %h want %h", gfx_data, exp_word(a)); end
        $display("reset mid-fetch: addr=%h refetched data=%h", a, gfx_data);
    endtask

    task automatic test_cs_gap;
        logic [17:0] a;
        bit          got;
        do_reset();
        a        = 18'($urandom);
        gfx_cs   = 1'b1;
        gfx_addr = a;
        wait_ok(20, got);
        vectors++; if (!got) begin miscompares++; $display("FAIL gap_first: got no ok want ok within 20 cycles"); end
        vectors++; if (hs_q.size() != 2) begin miscompares++; $display("FAIL gap_first_hs: got %0d want 2", hs_q.size()); end
        gfx_cs = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            vectors++; if (gfx_ok !== 1'b0) begin miscompares++; $display("FAIL gap_low_ok cyc%0d: got %b want 0", i, gfx_ok); end
        end
        gfx_cs = 1'b1;
        #1;
`ifdef JTBUBL_ROMFETCH_CACHE_EN
        vectors++; if (gfx_ok !== 1'b1) begin miscompares++; $display("FAIL gap_hit_ok: got %b want 1", gfx_ok); end
        vectors++; if (gfx_data !== exp_word(a)) begin miscompares++; $display("FAIL gap_hit_data: got %h want %h", gfx_data, exp_word(a)); end
        tick(10);
        vectors++; if (hs_q.size() != 2) begin miscompares++; $display("FAIL gap_hit_hs: got %0d want 2", hs_q.size()); end
`else
        vectors++; if (gfx_ok !== 1'b0) begin miscompares++; $display("FAIL gap_miss_ok: got %b want 0", gfx_ok); end
        wait_ok(20, got);
        vectors++; if (!got) begin miscompares++; $display("FAIL gap_refetch: got no ok want ok within 20 cycles"); end
        vectors++; if (hs_q.size() != 4) begin miscompares++; $display("FAIL gap_refetch_hs: got %0d want 4", hs_q.size()); end
        vectors++; if (gfx_data !== exp_word(a)) begin miscompares++; $display("FAIL gap_refetch_data: got %h want %h", gfx_data, exp_word(a)); end
`endif
        $display("cs gap: addr=%h handshakes=%0d data=%h", a, hs_q.size(), gfx_data);
    endtask

    // Random traffic: any flagged word must match memory, and a steady request must be served.
    task automatic test_random;
        logic [17:0] pool[4];
        logic [17:0] cur_a;
        logic        cur_cs;
        int          run;
        int          len;
        do_reset();
        for (int i = 0; i < 4; i++) pool[i] = 18'($urandom);
        run = 0;
        for (int seg = 0; seg < 60; seg++) begin
            ack_wait = int'($urandom_range(0, 2));
            rdy_gap  = int'($urandom_range(1, 3));
            cur_cs   = ($urandom_range(0, 4) != 0);
            cur_a    = pool[$urandom_range(0, 3)];
            if (cur_cs !== gfx_cs || cur_a !== gfx_addr) run = 0;
            gfx_cs   = cur_cs;
            gfx_addr = cur_a;
            len      = int'($urandom_range(1, 40));
            for (int j = 0; j < len; j++) begin
                tick(1);
                run++;
                if (gfx_ok) begin
                    vectors++; if (gfx_data !== exp_word(gfx_addr)) begin miscompares++; $display("FAIL rnd_data seg%0d: got %h want %h", seg, gfx_data, exp_word(gfx_addr)); end
                end
                if (!gfx_cs) begin
                    vectors++; if (gfx_ok !== 1'b0) begin miscompares++; $display("FAIL rnd_ok_cs_low seg%0d: got %b want 0", seg, gfx_ok); end
                end else if (run >= 30) begin
                    vectors++; if (gfx_ok !== 1'b1) begin miscompares++; $display("FAIL rnd_served seg%0d: got %b want 1 after %0d steady cycles", seg, gfx_ok, run); end
                end
            end
            $display("rnd seg %0d: cs=%b addr=%h cycles=%0d ok=%b", seg, gfx_cs, gfx_addr, len, gfx_ok);
        end
        gfx_cs = 1'b0;
        tick(30);
        vectors++; if (hs_q.size() % 2 != 0) begin miscompares++; $display("FAIL rnd_hs_even: got %0d want even", hs_q.size()); end
        for (int i = 0; i + 1 < hs_q.size(); i += 2) begin
            vectors++; if (hs_q[i][0] !== 1'b0 || hs_q[i + 1] !== {hs_q[i][18:1], 1'b1}) begin miscompares++; $display("FAIL rnd_hs_pair %0d: got %h,%h want even then odd of same word", i, hs_q[i], hs_q[i + 1]); end
        end
        vectors++; if (unstable != 0) begin miscompares++; $display("FAIL rnd_addr_stable: got %0d changes want 0", unstable); end
    endtask

    initial begin
        test_reset();
        test_basic_miss();
        test_hold();
        test_addr_change();
        test_slow_sdram();
        test_reset_mid_fetch();
        test_cs_gap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
